// File: rtl/fft_loop_test_nios2_gen2_0_cpu_debug_host_pkg.sv
// Shared types and constants for the Nios II debug-host virtual-JTAG scan engine.
// Holds the scan FSM states, the virtual IR codes and the default scan geometry.
package fft_loop_test_nios2_gen2_0_cpu_debug_host_pkg;

  localparam int DR_WIDTH_DEFAULT = 38;
  localparam int TCK_DIV_DEFAULT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RSP
  } state_e;

  // Virtual IR values understood by the debug slave.
  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'b00,
    IR_TRACE     = 2'b01,
    IR_BREAK     = 2'b10,
    IR_TRACECTRL = 2'b11
  } ir_code_e;

endpackage

// File: rtl/fft_loop_test_nios2_gen2_0_cpu_debug_host_tckgen.sv
// Divided test clock: tck is low for TCK_DIV clk cycles then high for TCK_DIV,
// with single-cycle strobes marking the clk edge on which tck rises or falls.
module fft_loop_test_nios2_gen2_0_cpu_debug_host_tckgen
  import fft_loop_test_nios2_gen2_0_cpu_debug_host_pkg::*;
#(
  parameter int TCK_DIV = TCK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int HC_W = $clog2(TCK_DIV + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_DIV - 1);

  logic [HC_W-1:0] half_cnt;
  logic            half_done;

  assign half_done = run && (half_cnt == HC_LAST);
  // Strobes are asserted in the cycle before tck changes, so they coincide with the edge.
  assign rise      = half_done && !tck;
  assign fall      = half_done && tck;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      tck      <= ~tck;
    end else begin
      half_cnt <= half_cnt + HC_W'(1);
    end
  end

endmodule

// File: rtl/fft_loop_test_nios2_gen2_0_cpu_debug_host.sv
// Debug-host scan engine: takes one IR/DR command, walks the virtual-JTAG
// UIR/CDR/SDR/UDR/RTI sequence against the debug slave and returns the captured DR.
module fft_loop_test_nios2_gen2_0_cpu_debug_host
  import fft_loop_test_nios2_gen2_0_cpu_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int TCK_DIV  = TCK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  localparam int BC_W = $clog2(DR_WIDTH + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH - 1);

  state_e              state;
  state_e              state_next;
  logic [1:0]          ir_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [BC_W-1:0]     bit_cnt;
  logic                tdi_q;
  logic [1:0]          rsp_ir_q;
  logic                scan_active;
  logic                tck_rise;
  logic                tck_fall;
  logic                cmd_fire;
  logic                rsp_fire;
  logic                last_bit;

  assign scan_active = (state != ST_IDLE) && (state != ST_RSP);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign rsp_fire    = rsp_valid && rsp_ready;
  assign last_bit    = (bit_cnt == BC_LAST);

  fft_loop_test_nios2_gen2_0_cpu_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (scan_active),
    .tck     (vji_tck),
    .rise    (tck_rise),
    .fall    (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Every scan state ends on a tck falling edge, so each lasts whole tck periods.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      ST_IDLE: if (cmd_fire)             state_next = ST_UIR;
      ST_UIR:  if (tck_fall)             state_next = ST_CDR;
      ST_CDR:  if (tck_fall)             state_next = ST_SDR;
      ST_SDR:  if (tck_fall && last_bit) state_next = ST_UDR;
      ST_UDR:  if (tck_fall)             state_next = ST_RTI;
      ST_RTI:  if (tck_fall)             state_next = ST_RSP;
      ST_RSP:  if (rsp_fire)             state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // NOTE: the shift register is reset too, because rsp_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q     <= '0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      tdi_q    <= 1'b0;
      rsp_ir_q <= '0;
    end else begin
      if (cmd_fire) begin
        ir_q    <= cmd_ir;
        shift_q <= cmd_data;
      end
      if (state == ST_UIR && tck_rise) rsp_ir_q <= vji_ir_out;
      if (state == ST_SDR && tck_rise) shift_q <= {vji_tdo, shift_q[DR_WIDTH-1:1]};
      if (state == ST_SDR && tck_fall) bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
      // tdi moves only on falling tck, picking up the bit exposed by the last rise.
      if (tck_fall) tdi_q <= (state_next == ST_SDR) ? shift_q[0] : 1'b0;
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign rsp_data  = shift_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_tdi   = tdi_q;
  assign vji_uir   = (state == ST_UIR);
  assign vji_cdr   = (state == ST_CDR);
  assign vji_sdr   = (state == ST_SDR);
  assign vji_udr   = (state == ST_UDR);
  assign vji_rti   = (state == ST_RTI);
  assign vji_ir_in = scan_active ? ir_q : 2'(IR_OCIMEM);

endmodule

// File: tb/tb_fft_loop_test_nios2_gen2_0_cpu_debug_host.sv
// Bench: behavioural virtual-JTAG slave (capture/shift or one-tck loopback) plus
// vector table, random scans and hand-written stall/hold/reset/small-config sequences.
module tb_fft_loop_test_nios2_gen2_0_cpu_debug_host;
  import fft_loop_test_nios2_gen2_0_cpu_debug_host_pkg::*;

  localparam int DR    = 38;
  localparam int TD    = 2;
  localparam int LAT   = (DR + 4) * 2 * TD;
  localparam int S_DR  = 8;
  localparam int S_LAT = (S_DR + 4) * 2 * 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    cmd_ir = '0, rsp_ir, vji_ir_in, vji_ir_out = '0;
  logic [DR-1:0] cmd_data = '0, rsp_data;
  logic          vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;

  fft_loop_test_nios2_gen2_0_cpu_debug_host #(.DR_WIDTH(DR), .TCK_DIV(TD)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti), .vji_ir_in(vji_ir_in),
    .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  // Small configuration: tdo wired straight back to tdi, so the captured DR equals the sent DR.
  logic            s_cmd_valid = 1'b0, s_cmd_ready, s_rsp_valid, s_rsp_ready = 1'b0;
  logic [1:0]      s_cmd_ir = '0, s_rsp_ir, s_vji_ir_in;
  logic [S_DR-1:0] s_cmd_data = '0, s_rsp_data;
  logic            s_vji_tck, s_vji_tdi, s_vji_uir, s_vji_cdr, s_vji_sdr, s_vji_udr, s_vji_rti;

  fft_loop_test_nios2_gen2_0_cpu_debug_host #(.DR_WIDTH(S_DR), .TCK_DIV(1)) u_small (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_ir(s_rsp_ir),
    .vji_tck(s_vji_tck), .vji_tdi(s_vji_tdi), .vji_uir(s_vji_uir), .vji_cdr(s_vji_cdr),
    .vji_sdr(s_vji_sdr), .vji_udr(s_vji_udr), .vji_rti(s_vji_rti), .vji_ir_in(s_vji_ir_in),
    .vji_tdo(s_vji_tdi), .vji_ir_out(2'b11)
  );

  // Behavioural slave, clocked by tck like a real TAP.
  logic          loop_mode = 1'b0;
  logic [DR-1:0] slv_capture = '0;
  logic [DR-1:0] slv_dr = '0;
  logic          slv_prev = 1'b0;

  always @(posedge vji_tck) begin
    if (vji_cdr) begin
      slv_dr   <= slv_capture;
      slv_prev <= 1'b0;
    end
    if (vji_sdr) begin
      slv_dr   <= {vji_tdi, slv_dr[DR-1:1]};
      slv_prev <= vji_tdi;
    end
  end
  assign vji_tdo = loop_mode ? slv_prev : slv_dr[0];

  // Monitors: udr pulse count, what the slave held at udr, IR seen during uir, invariants.
  int            udr_pulses = 0;
  logic          udr_prev = 1'b0;
  logic [DR-1:0] slv_at_udr = '0;
  logic [1:0]    ir_at_uir = '0;
  int            viol = 0;
  int            s_sdr_rises = 0;

  always @(posedge clk) begin
    udr_prev <= vji_udr;
    if (vji_udr && !udr_prev) begin
      udr_pulses <= udr_pulses + 1;
      slv_at_udr <= slv_dr;
    end
    if (vji_uir) ir_at_uir <= vji_ir_in;
  end

  always @(negedge clk) begin
    if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) viol <= viol + 1;
    else if (!(vji_uir || vji_cdr || vji_sdr || vji_udr || vji_rti) &&
             (vji_tck || vji_tdi || vji_ir_in != 2'b00)) viol <= viol + 1;
  end

  always @(posedge s_vji_tck) if (s_vji_sdr) s_sdr_rises <= s_sdr_rises + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          loop;
    logic [1:0]    ir;
    logic [1:0]    ir_out;
    logic [DR-1:0] data;
    logic [DR-1:0] cap;
    logic [DR-1:0] exp_data;
    logic [1:0]    exp_ir;
  } vec_t;

  vec_t vecs[8];

  // Reference: loopback returns what was sent, one bit later (first bit 0); otherwise the capture.
  function automatic logic [DR-1:0] ref_rsp(input vec_t v);
    logic [DR-1:0] sent;
    sent = v.data;
    return v.loop ? (sent << 1) : v.cap;
  endfunction

  task automatic do_scan(input vec_t v, input bit hold_valid, input int stall, input string tag);
    int            lat;
    int            pulses0;
    logic [DR-1:0] held;
    bit            ok;
    loop_mode   = v.loop;
    slv_capture = v.cap;
    vji_ir_out  = v.ir_out;
    pulses0     = udr_pulses;
    @(negedge clk);
    check({tag, " cmd_ready idle"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_ir    = v.ir;
    cmd_data  = v.data;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    if (!hold_valid) cmd_valid = 1'b0;
    while (!rsp_valid && lat < 4 * LAT) begin
      if (hold_valid) begin
        cmd_data = DR'({$urandom, $urandom});
        cmd_ir   = 2'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
    check({tag, " rsp_ir"}, 64'(rsp_ir), 64'(v.exp_ir));
    check({tag, " slave got dr"}, 64'(slv_at_udr), 64'(v.data));
    check({tag, " ir_in"}, 64'(ir_at_uir), 64'(v.ir));
    check({tag, " udr pulses"}, 64'(udr_pulses - pulses0), 64'(1));
    if (stall > 0) begin
      held      = rsp_data;
      ok        = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = ~v.data;
      repeat (stall) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== held || cmd_ready || vji_tck) ok = 1'b0;
      end
      cmd_valid = 1'b0;
      check({tag, " stall stable"}, 64'(ok), 64'(1));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " ready after accept"}, 64'(cmd_ready), 64'(1));
    check({tag, " rsp_valid dropped"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    int   lat;
    int   pulses0;
    int   rises0;
    vec_t v;

    vecs[0] = '{loop: 1'b1, ir: IR_BREAK, ir_out: IR_TRACECTRL, data: 38'h15_5555_5555,
                cap: '0, exp_data: 38'h2A_AAAA_AAAA, exp_ir: 2'b11};
    vecs[1] = '{loop: 1'b0, ir: IR_OCIMEM, ir_out: IR_TRACE, data: 38'h01_2345_6789,
                cap: 38'h2A_DEAD_BEEF, exp_data: 38'h2A_DEAD_BEEF, exp_ir: 2'b01};
    for (int i = 2; i < 8; i++) begin
      vecs[i].loop     = 1'($urandom);
      vecs[i].ir       = 2'($urandom);
      vecs[i].ir_out   = 2'($urandom);
      vecs[i].data     = DR'({$urandom, $urandom});
      vecs[i].cap      = DR'({$urandom, $urandom});
      vecs[i].exp_data = ref_rsp(vecs[i]);
      vecs[i].exp_ir   = vecs[i].ir_out;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset rsp_data", 64'(rsp_data), 64'(0));
    check("reset rsp_ir", 64'(rsp_ir), 64'(0));
    check("reset vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}), 64'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) do_scan(vecs[i], 1'b0, 0, $sformatf("vec%0d", i));

    // cmd_valid held high with churning data: only the first command runs
    v = vecs[1];
    v.data = 38'h3F_0F0F_1234;
    do_scan(v, 1'b1, 0, "hold_valid");

    // Response back-pressure for 50 cycles
    do_scan(vecs[0], 1'b0, 50, "stall");

    // Reset in the middle of shift bit 20
    loop_mode   = 1'b0;
    slv_capture = 38'h00_1111_2222;
    pulses0     = udr_pulses;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 38'h12_3456_789A;
    cmd_ir    = IR_TRACE;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (lat < 8 + 20 * 4 + 1) begin
      @(negedge clk);
      lat++;
    end
    check("abort in sdr", 64'(vji_sdr), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort vji", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}), 64'(0));
    check("abort rsp_data", 64'(rsp_data), 64'(0));
    check("abort rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (200) @(negedge clk);
    check("abort no udr", 64'(udr_pulses - pulses0), 64'(0));
    do_scan(vecs[1], 1'b0, 0, "after_abort");

    // Small configuration: DR_WIDTH=8, TCK_DIV=1
    rises0 = s_sdr_rises;
    @(negedge clk);
    check("small cmd_ready", 64'(s_cmd_ready), 64'(1));
    s_cmd_valid = 1'b1;
    s_cmd_ir    = IR_BREAK;
    s_cmd_data  = 8'hA5;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    s_cmd_valid = 1'b0;
    while (!s_rsp_valid && lat < 4 * S_LAT) begin
      @(negedge clk);
      lat++;
    end
    check("small latency", 64'(lat), 64'(S_LAT));
    check("small rsp_data", 64'(s_rsp_data), 64'(8'hA5));
    check("small rsp_ir", 64'(s_rsp_ir), 64'(2'b11));
    check("small sdr periods", 64'(s_sdr_rises - rises0), 64'(S_DR));
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    check("small ready after accept", 64'(s_cmd_ready), 64'(1));

    check("strobe/idle invariants", 64'(viol), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
